// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the FSM state encoding and the {addr,data} prefetch entry.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; exposes occupancy and head entry.
// Serves both as the prefetch data buffer and the issued-address tag queue.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
    output logic [WIDTH-1:0]             head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch stage: sequential fetch into a FIFO,
// presents the word matching PC, flushes and restarts on a broken sequence.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC,
    input  logic            InstrAck,
    output logic [XLEN-1:0] Instr,
    output logic            InstrValid,
    output logic            Stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fptr_q, fptr_d;
    logic [CW-1:0]   disc_q, disc_d;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   outst;
    fifo_entry_t     head;
    fifo_entry_t     push_entry;
    logic [XLEN-1:0] tag_head;
    logic            room;
    logic            issue;
    logic            push;
    logic            pop;
    logic            mismatch;
    logic            redirect;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_data (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (redirect),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .cnt_o   (cnt),
        .head_o  (head)
    );

    // Tags are never cleared: stale requests still retire one per response.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_tag (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (1'b0),
        .push_i  (issue),
        .wdata_i (fptr_q),
        .pop_i   (imem_rvalid),
        .cnt_o   (outst),
        .head_o  (tag_head)
    );

    assign room      = ({1'b0, cnt} + {1'b0, outst}) < (CW+1)'(DEPTH);
    assign imem_req  = reset && (state_q == RUN) && room;
    assign imem_addr = fptr_q;
    assign issue     = imem_req && imem_gnt;

    assign InstrValid = (cnt != '0) && (head.addr == PC);
    assign Instr      = InstrValid ? head.data : '0;
    assign Stall      = ~InstrValid;
    assign pop        = InstrAck && InstrValid;

    assign mismatch = (cnt != '0)   ? (head.addr != PC) :
                      (outst == '0) ? (fptr_q != PC)    :
                                      (tag_head != PC);
    assign redirect = (state_q == RUN) && mismatch;

    assign push       = (state_q == RUN) && imem_rvalid && !redirect;
    assign push_entry = '{addr: tag_head, data: imem_rdata};

    always_comb begin
        state_d = state_q;
        fptr_d  = fptr_q;
        disc_d  = disc_q;
        unique case (state_q)
            RUN: begin
                if (issue) begin
                    fptr_d = fptr_q + XLEN'(INSTR_BYTES);
                end
                if (redirect) begin
                    fptr_d  = PC;
                    disc_d  = outst + CW'(issue) - CW'(imem_rvalid);
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                fptr_d = PC;
                if (imem_rvalid && (disc_q != '0)) begin
                    disc_d = disc_q - 1'b1;
                end
                if (disc_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fptr_q  <= RESET_PC;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            fptr_q  <= fptr_d;
            disc_q  <= disc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC = '0;
    logic        InstrAck = 1'b0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .InstrAck    (InstrAck),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .Stall       (Stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int ack_pct = 0;
    int jmp_pct = 0;
    int sjmp_pct = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    last_due = -1;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } oq_t;
    oq_t         oq[$];
    logic [31:0] fq[$];
    logic [31:0] m_fptr = RPC;
    bit          m_flush = 1'b0;

    logic [31:0] iss_log[$];
    logic [31:0] acc_log[$];
    logic [31:0] pc = RPC;

    logic        s_req, s_valid, s_stall, s_rvalid;
    logic [31:0] s_addr, s_instr;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
    } t1_t;
    t1_t t1[6];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
    endfunction

    function automatic logic [31:0] rndpc();
        return 32'($urandom_range(255)) << 2;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        InstrAck = 1'b0;
        mq.delete();
        oq.delete();
        fq.delete();
        m_fptr = RPC;
        m_flush = 1'b0;
        last_due = -1;
        pc = RPC;
        PC = pc;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {imem_req, InstrValid, Stall, Instr},
              {1'b0, 1'b0, 1'b1, 32'h0});
        reset = 1'b1;
    endtask

    task automatic cycle();
        bit  rv, mv, mr, redir;
        int  lat, due;
        oq_t r;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata = rv ? memfn(mq[0].addr) : $urandom();
        InstrAck = ($urandom_range(99) < ack_pct);
        PC = pc;
        #2;
        s_req = imem_req;
        s_addr = imem_addr;
        s_valid = InstrValid;
        s_stall = Stall;
        s_instr = Instr;
        s_rvalid = rv;
        mv = (fq.size() > 0) && (fq[0] == pc);
        mr = !m_flush && ((fq.size() + oq.size()) < DEPTH);
        check("model",
              {s_valid, s_stall, s_req, s_req ? s_addr : 32'h0, s_instr},
              {mv, !mv, mr, mr ? m_fptr : 32'h0, mv ? memfn(pc) : 32'h0});
        if (InstrAck && s_valid) acc_log.push_back(s_instr);
        // memory side reacts to what the DUT actually asked for
        if (s_req && imem_gnt) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{s_addr, due});
            iss_log.push_back(s_addr);
        end
        if (rv) void'(mq.pop_front());
        if (m_flush) redir = 1'b0;
        else if (fq.size() > 0) redir = (fq[0] != pc);
        else if (oq.size() == 0) redir = (m_fptr != pc);
        else redir = (oq[0].addr != pc);
        if (InstrAck && mv) void'(fq.pop_front());
        if (rv && oq.size() > 0) begin
            r = oq.pop_front();
            if (!r.stale && !redir) fq.push_back(r.addr);
        end
        if (mr && imem_gnt) begin
            oq.push_back('{m_fptr, 1'b0});
            m_fptr += 4;
        end
        if (redir) begin
            fq.delete();
            foreach (oq[i]) oq[i].stale = 1'b1;
            m_fptr = pc;
            m_flush = 1'b1;
        end else if (m_flush) begin
            m_fptr = pc;
            m_flush = 1'b0;
            foreach (oq[i]) if (oq[i].stale) m_flush = 1'b1;
        end
        if (InstrAck && mv)
            pc = ($urandom_range(99) < jmp_pct) ? rndpc() : pc + 32'd4;
        else if ($urandom_range(99) < sjmp_pct)
            pc = rndpc();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] a);
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (s_valid) break;
        end
        check(name, {s_valid, s_instr}, {1'b1, memfn(a)});
    endtask

    task automatic flush_len(input string name, input int want,
                             input logic [31:0] target);
        int          base, nfl;
        logic [31:0] ra;
        base = iss_log.size();
        nfl = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_req) break;
            nfl++;
        end
        check({name, "_flush_cycles"}, 128'(nfl), 128'(want));
        ra = (iss_log.size() > base) ? iss_log[base] : 32'hFFFF_FFFF;
        check({name, "_restart_addr"}, ra, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, nvalid;
        logic [31:0] a;

        t1[0] = '{1'b1, 32'h0, 1'b0};
        t1[1] = '{1'b1, 32'h4, 1'b0};
        t1[2] = '{1'b1, 32'h8, 1'b1};
        t1[3] = '{1'b1, 32'hC, 1'b1};
        t1[4] = '{1'b0, 32'h0, 1'b1};
        t1[5] = '{1'b0, 32'h0, 1'b1};

        // cold start, latency 1, PC held: fills up then stops requesting
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t1_vec",
                  {s_req, s_req ? s_addr : 32'h0, s_valid, s_stall, s_instr},
                  {t1[i].req, t1[i].req ? t1[i].addr : 32'h0, t1[i].valid,
                   !t1[i].valid, t1[i].valid ? memfn(32'h0) : 32'h0});
        end

        // streaming with an always-accepting core
        ack_pct = 100;
        acc_log.delete();
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_valid) nvalid++;
        end
        check("t2_valid_every_cycle", 128'(nvalid), 128'(40));
        for (int i = 0; i < 16; i++) begin
            a = (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
            check("t2_stream_word", a, memfn(32'(i * 4)));
        end
        ack_pct = 0;

        // redirect with two requests in flight
        do_reset();
        lat_min = 3;
        lat_max = 3;
        cycle();
        cycle();
        gnt_pct = 0;
        pc = 32'h100;
        cycle();
        gnt_pct = 100;
        flush_len("t3", 2, 32'h100);
        wait_valid("t3_instr", 32'h100);

        // grant withheld: request and address must hold steady
        do_reset();
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4_hold", {s_req, s_addr, s_valid, s_stall},
                  {1'b1, 32'h0, 1'b0, 1'b1});
        end
        gnt_pct = 100;
        base = iss_log.size();
        repeat (8) cycle();
        check("t4_issue_count", 128'(iss_log.size() - base), 128'(4));
        for (int i = 0; i < 4; i++) begin
            a = (iss_log.size() > base + i) ? iss_log[base + i] : 32'hFFFF_FFFF;
            check("t4_issue_addr", a, 32'(i * 4));
        end

        // latency 3, redirect lands on a response cycle
        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (3) cycle();
        pc = 32'h200;
        cycle();
        check("t5_rvalid_on_redirect", 128'(s_rvalid), 128'(1));
        flush_len("t5", 3, 32'h200);
        wait_valid("t5_instr", 32'h200);

        // asynchronous reset in the middle of a burst
        do_reset();
        lat_min = 2;
        lat_max = 2;
        repeat (4) cycle();
        check("t6_pre_valid", 128'(InstrValid), 128'(1));
        #1 reset = 1'b0;
        #1;
        check("t6_async", {imem_req, InstrValid, Stall, Instr},
              {1'b0, 1'b0, 1'b1, 32'h0});
        do_reset();
        cycle();
        check("t6_restart", {s_req, s_addr}, {1'b1, RPC});
        wait_valid("t6_instr", RPC);

        // randomized traffic
        do_reset();
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 4;
        ack_pct = 70;
        jmp_pct = 10;
        sjmp_pct = 3;
        repeat (1500) cycle();
        do_reset();
        repeat (1500) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
